r2_pbc_filter_pipe: RTL and testbench

- Parametrised fixed-point successor to the floating-point r2 unit with periodic boundary correction (PBC).
- Takes a reference/neighbour position pair and computes the PBC-corrected dx, dy, dz and r2 = dx²+dy²+dz².
- Optionally drops pairs at or beyond the cutoff, or with r2 = 0 (self pair).
- Adds a valid/ready handshake with stall, a tag pass-through and pass/drop counters. Sits between the neighbour-cell reader and the force evaluator.

---
 rtl/r2_pbc_pkg.sv | 26 ++
 rtl/pbc_wrap_axis.sv | 55 +++++
 rtl/r2_pbc_filter_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_r2_pbc_filter_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r2_pbc_pkg.sv
// Shared constants and width helpers for the fixed-point r2/PBC filter pipeline.
package r2_pbc_pkg;

  // Fixed-point coordinate format defaults (Q15.16 signed).
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefFracBits  = 16;
  localparam int unsigned DefTagWidth  = 16;
  localparam int unsigned DefCntWidth  = 32;

  // Default simulation box (59.5 x 51.0 x 51.0) and squared cutoff (8.5^2 = 72.25).
  localparam logic [31:0] DefBoxX    = 32'h003B8000;
  localparam logic [31:0] DefBoxY    = 32'h00330000;
  localparam logic [31:0] DefBoxZ    = 32'h00330000;
  localparam logic [63:0] DefCutoff2 = 64'h00000048_40000000;

  // Raw difference of two coordinates needs one guard bit.
  function automatic int unsigned diff_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

  // r2 keeps the full product width; fraction bits double as well.
  function automatic int unsigned r2_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/pbc_wrap_axis.sv
// One axis of the pipeline front end: S1 subtract, S2 periodic-boundary wrap.
module pbc_wrap_axis
  import r2_pbc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DefDataWidth,
  parameter logic [DATA_WIDTH-1:0] BOX        = DefBoxX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] ref_pos,
  input  logic [DATA_WIDTH-1:0] nb_pos,
  output logic [DATA_WIDTH-1:0] delta
);

  localparam int unsigned DiffW = diff_width(DATA_WIDTH);
  // One extra bit so d +/- BOX cannot overflow before truncation.
  localparam int unsigned WideW = DiffW + 1;

  localparam logic signed [WideW-1:0] BoxS  = WideW'(BOX);
  localparam logic signed [WideW-1:0] HalfS = BoxS >>> 1;

  logic signed [DiffW-1:0]      d_d, d_q;
  logic signed [WideW-1:0]      d_ext;
  logic        [DATA_WIDTH-1:0] delta_d;

  // S1: signed difference with a guard bit.
  always_comb begin
    d_d = $signed({ref_pos[DATA_WIDTH-1], ref_pos}) - $signed({nb_pos[DATA_WIDTH-1], nb_pos});
  end

  // S2: fold the difference into [-HALF, +HALF]; exactly +/-HALF is left alone.
  always_comb begin
    d_ext = WideW'(d_q);
    if (d_ext > HalfS) begin
      delta_d = DATA_WIDTH'(d_ext - BoxS);
    end else if (d_ext < -HalfS) begin
      delta_d = DATA_WIDTH'(d_ext + BoxS);
    end else begin
      delta_d = DATA_WIDTH'(d_ext);
    end
  end

  // S1/S2 registers, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      delta <= '0;
    end else if (adv) begin
      d_q   <= d_d;
      delta <= delta_d;
    end
  end

endmodule

// File: rtl/r2_pbc_filter_pipe.sv
// Fixed-point PBC distance pipeline: deltas, r2, cutoff/self filter, handshake and counters.
module r2_pbc_filter_pipe
  import r2_pbc_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH     = DefDataWidth,
  parameter int unsigned             FRAC_BITS      = DefFracBits,
  parameter int unsigned             TAG_WIDTH      = DefTagWidth,
  parameter int unsigned             CNT_WIDTH      = DefCntWidth,
  parameter logic [DATA_WIDTH-1:0]   BOUNDING_BOX_X = DefBoxX,
  parameter logic [DATA_WIDTH-1:0]   BOUNDING_BOX_Y = DefBoxY,
  parameter logic [DATA_WIDTH-1:0]   BOUNDING_BOX_Z = DefBoxZ,
  parameter logic [2*DATA_WIDTH-1:0] CUTOFF2        = DefCutoff2,
  parameter bit                      FILTER_EN      = 1'b1,
  parameter bit                      EXCLUDE_SELF   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   refx,
  input  logic [DATA_WIDTH-1:0]   refy,
  input  logic [DATA_WIDTH-1:0]   refz,
  input  logic [DATA_WIDTH-1:0]   neighborx,
  input  logic [DATA_WIDTH-1:0]   neighbory,
  input  logic [DATA_WIDTH-1:0]   neighborz,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0]   dx_out,
  output logic [DATA_WIDTH-1:0]   dy_out,
  output logic [DATA_WIDTH-1:0]   dz_out,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [CNT_WIDTH-1:0]    pass_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  input  logic                    cnt_clr,
  output logic                    busy
);

  localparam int unsigned R2W = r2_width(DATA_WIDTH);

  // The r2 format only makes sense with at least one integer bit per coordinate.
  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DATA_WIDTH");
  end

  logic adv, accept;
  logic pass_ev, drop_ev;

  // Stage valids and tags, S1..S5.
  logic                 v1_q, v2_q, v3_q, v4_q, v5_q;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q, tag4_q, tag5_q;

  // Deltas: produced at S2, carried alongside the arithmetic to the output.
  logic [DATA_WIDTH-1:0] s2_dx, s2_dy, s2_dz;
  logic [DATA_WIDTH-1:0] s3_dx_q, s3_dy_q, s3_dz_q;
  logic [DATA_WIDTH-1:0] s4_dx_q, s4_dy_q, s4_dz_q;
  logic [DATA_WIDTH-1:0] s5_dx_q, s5_dy_q, s5_dz_q;

  logic [R2W-1:0] sq_x_d, sq_y_d, sq_z_d;
  logic [R2W-1:0] sq_x_q, sq_y_q, sq_z_q, sq_z4_q;
  logic [R2W:0]   sum_xy_d, sum_xy_q;
  logic [R2W+1:0] sum_xyz;
  logic [R2W-1:0] r2_d, r2_5_q;
  logic           drop_d, drop5_q;

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    accept   = in_valid && in_ready;
    busy     = v1_q || v2_q || v3_q || v4_q || v5_q || out_valid;
  end

  pbc_wrap_axis #(
    .DATA_WIDTH(DATA_WIDTH),
    .BOX       (BOUNDING_BOX_X)
  ) u_wrap_x (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .ref_pos(refx),
    .nb_pos (neighborx),
    .delta  (s2_dx)
  );

  pbc_wrap_axis #(
    .DATA_WIDTH(DATA_WIDTH),
    .BOX       (BOUNDING_BOX_Y)
  ) u_wrap_y (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .ref_pos(refy),
    .nb_pos (neighbory),
    .delta  (s2_dy)
  );

  pbc_wrap_axis #(
    .DATA_WIDTH(DATA_WIDTH),
    .BOX       (BOUNDING_BOX_Z)
  ) u_wrap_z (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .ref_pos(refz),
    .nb_pos (neighborz),
    .delta  (s2_dz)
  );

  // S3 squares, S4 partial sum, S5 final sum with saturation and the drop decision.
  always_comb begin
    sq_x_d   = $unsigned(R2W'($signed(s2_dx)) * R2W'($signed(s2_dx)));
    sq_y_d   = $unsigned(R2W'($signed(s2_dy)) * R2W'($signed(s2_dy)));
    sq_z_d   = $unsigned(R2W'($signed(s2_dz)) * R2W'($signed(s2_dz)));
    sum_xy_d = {1'b0, sq_x_q} + {1'b0, sq_y_q};
    sum_xyz  = {1'b0, sum_xy_q} + {2'b00, sq_z4_q};
    r2_d     = (sum_xyz[R2W+1:R2W] != 2'b00) ? '1 : sum_xyz[R2W-1:0];
    drop_d   = (FILTER_EN && (r2_d >= CUTOFF2)) || (EXCLUDE_SELF && (r2_d == '0));
  end

  // Valid and tag shift chain; bubbles travel as invalid slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      v5_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      tag4_q <= '0;
      tag5_q <= '0;
    end else if (adv) begin
      v1_q   <= accept;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      v4_q   <= v3_q;
      v5_q   <= v4_q;
      tag1_q <= in_tag;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
      tag4_q <= tag3_q;
      tag5_q <= tag4_q;
    end
  end

  // Arithmetic stage registers S3..S5.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_x_q   <= '0;
      sq_y_q   <= '0;
      sq_z_q   <= '0;
      sq_z4_q  <= '0;
      sum_xy_q <= '0;
      r2_5_q   <= '0;
      drop5_q  <= 1'b0;
      s3_dx_q  <= '0;
      s3_dy_q  <= '0;
      s3_dz_q  <= '0;
      s4_dx_q  <= '0;
      s4_dy_q  <= '0;
      s4_dz_q  <= '0;
      s5_dx_q  <= '0;
      s5_dy_q  <= '0;
      s5_dz_q  <= '0;
    end else if (adv) begin
      sq_x_q   <= sq_x_d;
      sq_y_q   <= sq_y_d;
      sq_z_q   <= sq_z_d;
      sq_z4_q  <= sq_z_q;
      sum_xy_q <= sum_xy_d;
      r2_5_q   <= r2_d;
      drop5_q  <= drop_d;
      s3_dx_q  <= s2_dx;
      s3_dy_q  <= s2_dy;
      s3_dz_q  <= s2_dz;
      s4_dx_q  <= s3_dx_q;
      s4_dy_q  <= s3_dy_q;
      s4_dz_q  <= s3_dz_q;
      s5_dx_q  <= s4_dx_q;
      s5_dy_q  <= s4_dy_q;
      s5_dz_q  <= s4_dz_q;
    end
  end

  // Output register; dropped pairs load data but never raise out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r2        <= '0;
      dx_out    <= '0;
      dy_out    <= '0;
      dz_out    <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v5_q && !drop5_q;
      r2        <= r2_5_q;
      dx_out    <= s5_dx_q;
      dy_out    <= s5_dy_q;
      dz_out    <= s5_dz_q;
      out_tag   <= tag5_q;
    end
  end

  // Count each valid S5 pair once, at the moment it is loaded into the output register.
  always_comb begin
    pass_ev = adv && v5_q && !drop5_q;
    drop_ev = adv && v5_q && drop5_q;
  end

  // Saturating counters; clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_ev && (pass_cnt != '1)) begin
        pass_cnt <= pass_cnt + CNT_WIDTH'(1);
      end
      if (drop_ev && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_r2_pbc_filter_pipe.sv
// Directed bench for r2_pbc_filter_pipe; a second 4-bit-counter instance covers saturation.
module tb_r2_pbc_filter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst4, in_valid, out_ready, cnt_clr, cnt_clr4;
  logic [31:0] refx, refy, refz, nbx, nby, nbz;
  logic [15:0] in_tag;

  logic        in_ready, out_valid, busy;
  logic [63:0] r2;
  logic [31:0] dx_out, dy_out, dz_out, pass_cnt, drop_cnt;
  logic [15:0] out_tag;

  logic        in_ready4, out_valid4, busy4;
  logic [63:0] r2_4;
  logic [31:0] dx4, dy4, dz4;
  logic [15:0] tag4;
  logic [3:0]  pass_cnt4, drop_cnt4;

  r2_pbc_filter_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .refx     (refx),
    .refy     (refy),
    .refz     (refz),
    .neighborx(nbx),
    .neighbory(nby),
    .neighborz(nbz),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r2       (r2),
    .dx_out   (dx_out),
    .dy_out   (dy_out),
    .dz_out   (dz_out),
    .out_tag  (out_tag),
    .pass_cnt (pass_cnt),
    .drop_cnt (drop_cnt),
    .cnt_clr  (cnt_clr),
    .busy     (busy)
  );

  r2_pbc_filter_pipe #(
    .CNT_WIDTH(4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst4),
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .refx     (refx),
    .refy     (refy),
    .refz     (refz),
    .neighborx(nbx),
    .neighbory(nby),
    .neighborz(nbz),
    .in_tag   (in_tag),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .r2       (r2_4),
    .dx_out   (dx4),
    .dy_out   (dy4),
    .dz_out   (dz4),
    .out_tag  (tag4),
    .pass_cnt (pass_cnt4),
    .drop_cnt (drop_cnt4),
    .cnt_clr  (cnt_clr4),
    .busy     (busy4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until the DUT takes it (bounded).
  task automatic push(input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz,
                      input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
                      input logic [15:0] t);
    int guard;
    refx = rx; refy = ry; refz = rz;
    nbx = nx; nby = ny; nbz = nz;
    in_tag = t;
    in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accepting edge: result must appear exactly 5 edges later.
  task automatic expect_out(input string name, input logic [63:0] r2_e, input logic [31:0] dx_e,
                            input logic [31:0] dy_e, input logic [31:0] dz_e,
                            input logic [15:0] tag_e);
    repeat (4) step();
    check({name, "_early"}, out_valid, 0);
    step();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_r2"}, r2, r2_e);
    check({name, "_dx"}, dx_out, dx_e);
    check({name, "_dy"}, dy_out, dy_e);
    check({name, "_dz"}, dz_out, dz_e);
    check({name, "_tag"}, out_tag, tag_e);
  endtask

  // Called right after the accepting edge of a pair that must be filtered.
  task automatic expect_drop(input string name, input logic [31:0] drops_before);
    repeat (4) step();
    check({name, "_cnt_before"}, drop_cnt, drops_before);
    step();
    check({name, "_no_valid"}, out_valid, 0);
    check({name, "_cnt_after"}, drop_cnt, drops_before + 1);
  endtask

  // Output monitor: records transfers and checks stall behaviour.
  logic [15:0]  got_tag_q[$];
  logic [63:0]  got_r2_q[$];
  logic         hold_pend = 1'b0;
  logic [191:0] hold_val;

  initial begin
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        check("hold_stable", {out_valid, r2, dx_out, dy_out, dz_out, out_tag}, hold_val);
      end
      hold_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
      if (hold_pend) begin
        hold_val = {out_valid, r2, dx_out, dy_out, dz_out, out_tag};
        check("in_ready_stall", in_ready, 0);
      end
      if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
        got_tag_q.push_back(out_tag);
        got_r2_q.push_back(r2);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; cnt_clr4 = 1'b0;
    refx = '0; refy = '0; refz = '0; nbx = '0; nby = '0; nbz = '0; in_tag = '0;
    step();
    step();
    rst = 1'b0; rst4 = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_r2", r2, 0);
    check("rst_deltas", {dx_out, dy_out, dz_out, out_tag}, 0);
    check("rst_cnts", {pass_cnt, drop_cnt}, 0);

    // In-box pair: deltas (1,3,7), r2 = 59
    push(32'h00020000, 32'h00040000, 32'h00080000,
         32'h00010000, 32'h00010000, 32'h00010000, 16'h0001);
    check("t1_busy", busy, 1);
    expect_out("t1", 64'h0000003B_00000000, 32'h00010000, 32'h00030000, 32'h00070000, 16'h0001);
    check("t1_pass", pass_cnt, 1);

    // Wrap towards negative: deltas -0.5, r2 = 0.75
    push(32'h003B0000, 32'h00328000, 32'h00328000, 32'h0, 32'h0, 32'h0, 16'h0002);
    expect_out("t2a", 64'h00000000_C0000000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 16'h0002);
    // Wrap towards positive: deltas +0.5
    push(32'h0, 32'h0, 32'h0, 32'h003B0000, 32'h00328000, 32'h00328000, 16'h0003);
    expect_out("t2b", 64'h00000000_C0000000, 32'h00008000, 32'h00008000, 32'h00008000, 16'h0003);
    check("t2_pass", pass_cnt, 3);

    // Filtering: beyond cutoff, self pair, exactly at cutoff
    push(32'h00140000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0004);
    expect_drop("t3_far", 0);
    push(32'h00030000, 32'h00030000, 32'h00030000,
         32'h00030000, 32'h00030000, 32'h00030000, 16'h0005);
    expect_drop("t3_self", 1);
    push(32'h00088000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0006);
    expect_drop("t3_edge", 2);
    check("t3_pass", pass_cnt, 3);

    // Counter clear coinciding with a pass event
    push(32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0007);
    repeat (4) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t5_clr_valid", out_valid, 1);
    check("t5_clr_pass", pass_cnt, 0);
    check("t5_clr_drop", drop_cnt, 0);
    push(32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0008);
    expect_out("t5", 64'h00000001_00000000, 32'h00010000, 32'h0, 32'h0, 16'h0008);
    check("t5_pass", pass_cnt, 1);

    // Backpressure: 8 back-to-back pairs with a 10-cycle stall mid-stream
    rst = 1'b1;
    step();
    rst = 1'b0;
    got_tag_q.delete();
    got_r2_q.delete();
    fork
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (10) step();
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      push(32'((i + 1) << 16), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'(16'h0100 + i));
    end
    for (int c = 0; c < 60 && got_tag_q.size() < 8; c++) step();
    repeat (6) step();
    check("t4_count", got_tag_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_tag_q.size()) begin
        check($sformatf("t4_tag%0d", i), got_tag_q[i], 16'(16'h0100 + i));
        check($sformatf("t4_r2_%0d", i), got_r2_q[i], 64'((i + 1) * (i + 1)) << 32);
      end
    end
    check("t4_pass", pass_cnt, 8);
    check("t4_idle", busy, 0);

    // Saturation: 20 passes into the 4-bit-counter instance
    rst = 1'b1; rst4 = 1'b1;
    step();
    rst = 1'b0; rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push(32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'(16'h0200 + i));
    end
    repeat (5) step();
    check("sat_out4", {out_valid4, in_ready4, r2_4, dx4, dy4, dz4, tag4},
          {1'b1, 1'b1, 64'h00000001_00000000, 32'h00010000, 32'h0, 32'h0, 16'h0213});
    step();
    check("sat_pass32", pass_cnt, 20);
    check("sat_pass4", pass_cnt4, 4'hF);
    check("sat_drop4", drop_cnt4, 0);
    check("sat_busy4", busy4, 0);

    // Reset with 3 pairs in flight
    got_tag_q.delete();
    got_r2_q.delete();
    for (int i = 0; i < 3; i++) begin
      push(32'h00020000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'(16'h0300 + i));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_cnts", {pass_cnt, drop_cnt}, 0);
    check("t6_regs", {r2, out_tag}, 0);
    repeat (10) step();
    check("t6_no_stale", got_tag_q.size(), 0);
    check("t6_still_idle", busy, 0);
    push(32'h00020000, 32'h00040000, 32'h00080000,
         32'h00010000, 32'h00010000, 32'h00010000, 16'h03AA);
    expect_out("t6", 64'h0000003B_00000000, 32'h00010000, 32'h00030000, 32'h00070000, 16'h03AA);
    step();
    check("t6_one_out", got_tag_q.size(), 1);
    if (got_tag_q.size() > 0) check("t6_out_tag", got_tag_q[0], 16'h03AA);
    check("t6_pass", pass_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
